// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two combinational read ports,
// optional same-cycle write bypass, optional hard-zero entry 0, sequential clear engine.
//
// state | meaning
// IDLE  | normal operation, writes accepted, waiting for clr_req
// CLEAR | zeroing entry[idx] each cycle, writes dropped
// DONE  | single-cycle completion pulse, writes dropped
module reg_file_param #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_err
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] IDX_LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW:0]   idx, idx_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_acc;

    assign busy     = (state != IDLE);
    assign clr_done = (state == DONE);
    assign wr_acc   = we && !busy && !(ZERO_R0 && (waddr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                idx_nxt = idx + (AW + 1)'(1);
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Dropped writes are flagged on the following cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= we && busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[idx[AW-1:0]] <= '0;
        end else if (wr_acc) begin
            mem[waddr] <= wdata;
        end
    end

    // Hard-zero entry 0 overrides bypass so it can never read non-zero.
    always_comb begin
        rdata_a = mem[raddr_a];
        if (BYPASS && wr_acc && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if (ZERO_R0 && (raddr_a == '0)) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (BYPASS && wr_acc && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
        if (ZERO_R0 && (raddr_b == '0)) begin
            rdata_b = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: two instances (ZERO_R0 off/on, bypass on)
// share stimulus; a cycle-level reference model plus directed tables and sequences.
module tb_reg_file_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       clr_req;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
    logic       busy0, busy1, done0, done1, err0, err1;

    int errors = 0;
    int checks = 0;

    // Reference model: plain arrays and a position counter within the clear
    // (0 = not clearing, 1..8 = zeroing entry pos-1, 9 = completion cycle).
    logic [7:0] m0 [8];
    logic [7:0] m1 [8];
    int         clr_pos;
    bit         prev_drop;

    logic [7:0] s_a0, s_b0, s_a1, s_b1;
    logic       s_busy0, s_done0, s_err0, s_err1;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] ea0;
        logic [7:0] eb0;
        logic [7:0] ea1;
        logic [7:0] eb1;
    } vec_t;

    vec_t tbl [8];

    reg_file_param #(.DW(8), .AW(3), .ZERO_R0(1'b0), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
        .clr_req(clr_req), .busy(busy0), .clr_done(done0), .wr_err(err0)
    );

    reg_file_param #(.DW(8), .AW(3), .ZERO_R0(1'b1), .BYPASS(1'b1)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
        .clr_req(clr_req), .busy(busy1), .clr_done(done1), .wr_err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 8'h00;
            m1[i] = 8'h00;
        end
        clr_pos   = 0;
        prev_drop = 1'b0;
    endtask

    function automatic logic [7:0] exp_rd(input bit z, input logic [2:0] a);
        bit acc;
        acc = we && (clr_pos == 0) && !(z && (waddr == 3'd0));
        if (z && (a == 3'd0)) return 8'h00;
        if (acc && (a == waddr)) return wdata;
        return z ? m1[a] : m0[a];
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model, pass the rising edge.
    task automatic step(input logic we_i, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic clr_i);
        bit was_busy;
        we      = we_i;
        waddr   = wa;
        wdata   = wd;
        raddr_a = ra;
        raddr_b = rb;
        clr_req = clr_i;
        @(negedge clk);
        s_a0 = rdata_a0; s_b0 = rdata_b0; s_a1 = rdata_a1; s_b1 = rdata_b1;
        s_busy0 = busy0; s_done0 = done0; s_err0 = err0; s_err1 = err1;
        chk("rd_a0", 32'(rdata_a0), 32'(exp_rd(1'b0, ra)));
        chk("rd_b0", 32'(rdata_b0), 32'(exp_rd(1'b0, rb)));
        chk("rd_a1", 32'(rdata_a1), 32'(exp_rd(1'b1, ra)));
        chk("rd_b1", 32'(rdata_b1), 32'(exp_rd(1'b1, rb)));
        chk("busy0", 32'(busy0), 32'(clr_pos != 0));
        chk("busy1", 32'(busy1), 32'(clr_pos != 0));
        chk("done0", 32'(done0), 32'(clr_pos == 9));
        chk("done1", 32'(done1), 32'(clr_pos == 9));
        chk("err0", 32'(err0), 32'(prev_drop));
        chk("err1", 32'(err1), 32'(prev_drop));
        was_busy = (clr_pos != 0);
        if (clr_pos >= 1 && clr_pos <= 8) begin
            m0[clr_pos-1] = 8'h00;
            m1[clr_pos-1] = 8'h00;
        end
        if (we && !was_busy) begin
            m0[waddr] = wdata;
            if (waddr != 3'd0) m1[waddr] = wdata;
        end
        prev_drop = we && was_busy;
        if (clr_pos == 0)      clr_pos = clr_req ? 1 : 0;
        else if (clr_pos == 9) clr_pos = 0;
        else                   clr_pos++;
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 3'(7 - i), 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy, done_at, n_done, n_rise, d1, r2;
        logic [2:0] err_hist;
        bit pb;

        tbl[0] = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd3, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        tbl[2] = '{1'b1, 3'd3, 8'hC3, 3'd3, 3'd3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
        tbl[3] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 8'hC3, 8'h00, 8'hC3, 8'h00};
        tbl[4] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'hFF, 8'hC3, 8'h00, 8'hC3};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 3'd5, 8'h12, 3'd5, 3'd3, 8'h12, 8'hC3, 8'h12, 8'hC3};
        tbl[7] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 8'h12, 8'hC3, 8'h12, 8'hC3};

        // Reset state
        rst = 1'b1; we = 1'b0; clr_req = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk("rst_rd_a", 32'(rdata_a0), 32'd0);
            chk("rst_rd_b", 32'(rdata_b1), 32'd0);
        end
        rst = 1'b0;

        // Directed table: write/read, bypass, hard-zero entry 0
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0);
            chk("tbl_a0", 32'(s_a0), 32'(tbl[i].ea0));
            chk("tbl_b0", 32'(s_b0), 32'(tbl[i].eb0));
            chk("tbl_a1", 32'(s_a1), 32'(tbl[i].ea1));
            chk("tbl_b1", 32'(s_b1), 32'(tbl[i].eb1));
            chk("tbl_err1", 32'(s_err1), 32'd0);
        end

        // Full clear with a write on the request cycle and a dropped write mid-clear
        fill();
        step(1'b1, 3'd7, 8'h99, 3'd7, 3'd6, 1'b1);
        chk("clr_req_wr_byp", 32'(s_a0), 32'h99);
        n_busy = 0; done_at = 0; err_hist = '0;
        for (int k = 0; k < 20; k++) begin
            step(k == 2, 3'd5, 8'h77, (k == 2) ? 3'd5 : 3'(k - 1), 3'd5, 1'b0);
            if (k == 2) chk("busy_no_byp", 32'(s_a0), 32'h66);
            if (k >= 2 && k <= 4) err_hist[k-2] = s_err0;
            if (!s_busy0) break;
            n_busy++;
            if (s_done0) done_at = n_busy;
        end
        chk("clr_busy_len", 32'(n_busy), 32'd9);
        chk("clr_done_pos", 32'(done_at), 32'd9);
        chk("wr_err_pulse", 32'(err_hist), 32'b010);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
            chk("after_clr", 32'(s_a0), 32'd0);
        end

        // Reset three cycles into a clear
        fill();
        step(1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0);
        we = 1'b0; clr_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(i);
            #1;
            chk("midrst_rd0", 32'(rdata_a0), 32'd0);
            chk("midrst_rd1", 32'(rdata_b1), 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 3'd6, 8'h42, 3'd6, 3'd6, 1'b0);
        step(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b0);
        chk("post_rst_wr", 32'(s_a0), 32'h42);

        // clr_req held high for 20 cycles
        n_done = 0; n_rise = 0; d1 = -1; r2 = -1; pb = 1'b0;
        for (int k = 0; k < 45; k++) begin
            step(1'b0, 3'd0, 8'h00, 3'(k), 3'(k + 3), k < 20);
            if (s_done0) begin
                n_done++;
                if (d1 < 0) d1 = k;
            end
            if (s_busy0 && !pb) begin
                n_rise++;
                if (n_rise == 2) r2 = k;
            end
            pb = s_busy0;
        end
        chk("held_done_cnt", 32'(n_done), 32'd2);
        chk("held_clr_cnt", 32'(n_rise), 32'd2);
        chk("held_idle_gap", 32'(r2 - d1), 32'd2);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
